cpu_core: RTL and testbench
===========================

# cpu_core

- Multi-cycle 8-bit-data / 16-bit-address processor core.
- Fetches 32-bit instructions from an external single-port instruction RAM.
- Reads and writes an external byte-wide data RAM that it shares with the I/O manager.
- Runs while `enable` is high and raises `finish` on HALT. The I/O manager loads the data RAM over UART, enables the core, waits for `finish`, then drains the RAM back out.

## Interface
Parameters: none.

Ports (`reset`: one clock; reset is asynchronous and active-low):
- clk  in  1  core clock (divided system clock)
- reset  in  1  async active-low reset
- enable  in  1  run permission; low = core frozen, memory buses idle
- data_ram_we  out  1  data RAM write strobe
- addr_data_ram  out  16  data RAM byte address
- din_data_ram  out  8  data RAM write data
- dout_data_ram  in  8  data RAM read data
- inst_ram_we  out  1  tied 0
- addr_inst_ram  out  10  instruction address (= PC)
- din_inst_ram  out  32  tied 0
- dout_inst_ram  in  32  instruction read data
- finish  out  1  program has executed HALT

## Operation
**State**
- 16 registers R0–R15, 16 bits each; R0 reads 0 and writes to it are discarded.
- 10-bit PC.
- 32-bit IR.

**Instruction format:** op[31:28], rd[27:24], rs[23:20], rt[19:16], imm[15:0].

**Opcodes**
- 0 NOP
- 1 LDI: rd=imm
- 2 ADD: rd=rs+rt
- 3 SUB: rd=rs−rt
- 4 AND: rd=rs&rt
- 5 OR: rd=rs|rt
- 6 LD: rd={8'h00, mem[rs+imm]}
- 7 ST: mem[rs+imm]=rt[7:0]
- 8 ADDI: rd=rs+imm
- 9 SHL: rd=rs<<imm[3:0]
- A SHR: rd=rs>>imm[3:0], logical
- B JMP: pc=imm[9:0]
- C JZ: if rs==0, pc=imm[9:0]
- D JNZ: if rs!=0, pc=imm[9:0]
- E MUL: see Configuration
- F HALT

**Arithmetic and wrap rules**
- All arithmetic is mod 2^16.
- Effective address rs+imm wraps mod 2^16.
- PC+1 wraps 1023→0.

**State machine**
- F0: drive addr_inst_ram=PC.
- F1: RAM latency wait.
- F2: IR←dout_inst_ram.
- EX: execute.
  - ALU/LDI/NOP ops write rd and set PC+1.
  - Jumps set PC to the target or PC+1.
  - ST drives addr/din with data_ram_we=1 for exactly this cycle, sets PC+1, then goes to F0.
  - LD drives the address, then goes to M1.
  - HALT sets finish=1 and goes to DONE.
- M1: wait.
- M2: rd←dout_data_ram, PC+1, go to F0.
- DONE: hold finish=1.

**Enable and re-arm**
- enable low in any state other than DONE: all registers frozen, data_ram_we=0.
- enable low while in DONE: re-arm. PC←0, finish←0, state←F0. Register contents are kept.

**Reset**
- All outputs 0, PC=0, IR=0, registers 0, state F0.
- Asserting reset mid-instruction aborts it; a pending ST is not written.

## Timing
- Both RAMs are synchronous with a 1-cycle read latency. The core samples read data 2 cycles after presenting the address.
- Cycles per instruction while enable is high:
  - ALU, LDI, NOP, jumps, ST, HALT: 4 (F0, F1, F2, EX).
  - LD: 6.
  - MUL: 4 when compiled in.
- finish rises the cycle after the HALT EX cycle and stays high until re-arm or reset.
- data_ram_we is never high for more than one consecutive cycle per ST.

## Configuration
- `CPU_CORE_MUL_EN` defined: opcode E is MUL, rd=(rs*rt)[15:0], single cycle in EX.
- `CPU_CORE_MUL_EN` undefined: opcode E executes as NOP and no multiplier is synthesized.

## Structure
- Package `cpu_core_pkg`: opcode constants, FSM state enum, instruction field bit positions.
- Sub-module `cpu_core_alu`: combinational ALU with op, a, b, shamt inputs and a 16-bit result. Includes the guarded multiplier.
- The register file and FSM stay in the top module.

## Test plan
1. Instruction RAM holds LDI R1,5; LDI R2,7; ADD R3,R1,R2; ST [R0+0],R3; HALT; enable=1 → data RAM[0]=0x0C, finish rises 20 cycles after enable.
2. Data RAM[0x0010]=0xA5; program LD R4,[R0+0x10]; ADDI R4,R4,1; ST [R0+0x11],R4; HALT → RAM[0x11]=0xA6, RAM[0x10] unchanged.
3. Loop LDI R1,3; SUBI-via-ADDI R1,R1,0xFFFF; JNZ R1,1; HALT → finish after exactly 3 JNZ executions; R1 ends at 0.
4. Drop enable for 10 cycles mid-program → no RAM writes during the gap; final RAM contents identical to an uninterrupted run.
5. After finish, drop enable for 1 cycle, then re-raise → finish clears, program reruns from PC 0, finish rises again.
6. Assert reset while in EX of a ST → no write occurs; all outputs read 0 during reset. With MUL enabled, 0x0010*0x0300 → rd=0x3000.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: opcode constants, FSM state encoding and instruction field
// positions shared by the core and its ALU.
// The MUL opcode counts as a register-writing instruction only when
// CPU_CORE_MUL_EN is defined.
package cpu_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int RT_MSB  = 19;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_F0,
        S_F1,
        S_F2,
        S_EX,
        S_M1,
        S_M2,
        S_DONE
    } state_t;

    // True for opcodes whose EX cycle writes the ALU result into rd.
    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_SHL, OP_SHR: writes_rd = 1'b1;
`ifdef CPU_CORE_MUL_EN
            OP_MUL:                  writes_rd = 1'b1;
`endif
            default:                 writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// cpu_core_alu: purely combinational 16-bit ALU for the core's EX cycle.
// The multiplier only exists when CPU_CORE_MUL_EN is defined; otherwise
// opcode E produces zero and the core treats it as a NOP.
module cpu_core_alu
    import cpu_core_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  shamt,
    output logic [15:0] result
);

    // Select the operation; all arithmetic wraps mod 2^16.
    always_comb begin
        result = '0;
        case (op)
            OP_LDI:          result = b;
            OP_ADD, OP_ADDI: result = a + b;
            OP_SUB:          result = a - b;
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_SHL:          result = a << shamt;
            OP_SHR:          result = a >> shamt;
`ifdef CPU_CORE_MUL_EN
            OP_MUL:          result = a * b;
`endif
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle core, 32-bit instructions from a synchronous
// instruction RAM, byte-wide shared data RAM. Holds register file and FSM.
// Define CPU_CORE_MUL_EN to make opcode E a single-cycle 16x16 multiply.
module cpu_core
    import cpu_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        data_ram_we,
    output logic [15:0] addr_data_ram,
    output logic [7:0]  din_data_ram,
    input  logic [7:0]  dout_data_ram,
    output logic        inst_ram_we,
    output logic [9:0]  addr_inst_ram,
    output logic [31:0] din_inst_ram,
    input  logic [31:0] dout_inst_ram,
    output logic        finish
);

    state_t      state;
    state_t      next_state;
    logic [9:0]  pc;
    logic [9:0]  pc_next;
    logic [31:0] ir;
    logic [15:0] regs [16];

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [15:0] eff_addr;

    assign op     = ir[OP_MSB:OP_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    assign rs_val   = (rs == 4'd0) ? 16'h0000 : regs[rs];
    assign rt_val   = (rt == 4'd0) ? 16'h0000 : regs[rt];
    assign alu_b    = (op == OP_LDI || op == OP_ADDI) ? imm : rt_val;
    assign eff_addr = rs_val + imm;

    assign inst_ram_we   = 1'b0;
    assign din_inst_ram  = '0;
    assign addr_inst_ram = pc;
    assign finish        = (state == S_DONE);

    cpu_core_alu u_alu (
        .op     (op),
        .a      (rs_val),
        .b      (alu_b),
        .shamt  (imm[3:0]),
        .result (alu_result)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_F0;
        end else begin
            state <= next_state;
        end
    end

    // Next state: freeze when enable is low, except DONE which re-arms to F0.
    always_comb begin
        next_state = state;
        if (!enable) begin
            if (state == S_DONE) begin
                next_state = S_F0;
            end
        end else begin
            case (state)
                S_F0:    next_state = S_F1;
                S_F1:    next_state = S_F2;
                S_F2:    next_state = S_EX;
                S_EX: begin
                    if (op == OP_HALT) begin
                        next_state = S_DONE;
                    end else if (op == OP_LD) begin
                        next_state = S_M1;
                    end else begin
                        next_state = S_F0;
                    end
                end
                S_M1:    next_state = S_M2;
                S_M2:    next_state = S_F0;
                S_DONE:  next_state = S_DONE;
                default: next_state = S_F0;
            endcase
        end
    end

    // Data RAM bus: address held through EX/M1/M2 of a load so the RAM
    // output is valid in M2; write strobe only in the EX cycle of a store.
    always_comb begin
        data_ram_we   = 1'b0;
        addr_data_ram = '0;
        din_data_ram  = '0;
        case (state)
            S_EX: begin
                if (op == OP_ST) begin
                    data_ram_we   = enable;
                    addr_data_ram = eff_addr;
                    din_data_ram  = rt_val[7:0];
                end else if (op == OP_LD) begin
                    addr_data_ram = eff_addr;
                end
            end
            S_M1, S_M2: addr_data_ram = eff_addr;
            default: ;
        endcase
    end

    // Program counter after EX: branch target, hold for LD/HALT, else PC+1.
    always_comb begin
        pc_next = pc + 10'd1;
        case (op)
            OP_JMP: pc_next = imm[9:0];
            OP_JZ:  if (rs_val == 16'h0000) pc_next = imm[9:0];
            OP_JNZ: if (rs_val != 16'h0000) pc_next = imm[9:0];
            OP_LD, OP_HALT: pc_next = pc;
            default: ;
        endcase
    end

    // Datapath registers: IR load, register writeback and PC update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            ir <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (!enable) begin
            if (state == S_DONE) begin
                pc <= '0;
            end
        end else begin
            case (state)
                S_F2: ir <= dout_inst_ram;
                S_EX: begin
                    pc <= pc_next;
                    if (writes_rd(op) && rd != 4'd0) begin
                        regs[rd] <= alu_result;
                    end
                end
                S_M2: begin
                    pc <= pc + 10'd1;
                    if (rd != 4'd0) begin
                        regs[rd] <= {8'h00, dout_data_ram};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs with hand-computed results for cpu_core,
// using behavioural synchronous instruction and data RAMs.
// Expected MUL results follow CPU_CORE_MUL_EN.
module tb_cpu_core;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        data_ram_we;
    logic [15:0] addr_data_ram;
    logic [7:0]  din_data_ram;
    logic [7:0]  dout_data_ram;
    logic        inst_ram_we;
    logic [9:0]  addr_inst_ram;
    logic [31:0] din_inst_ram;
    logic [31:0] dout_inst_ram;
    logic        finish;

    logic [31:0] inst_mem [1024];
    logic [7:0]  data_mem [65536];
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [7:0]  ld_data = 8'h00;
    int          we_count = 0;
    logic        we_prev = 1'b0;
    logic        we_burst_seen = 1'b0;

    int errors = 0;
    int checks = 0;

    cpu_core dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_ram_we   (data_ram_we),
        .addr_data_ram (addr_data_ram),
        .din_data_ram  (din_data_ram),
        .dout_data_ram (dout_data_ram),
        .inst_ram_we   (inst_ram_we),
        .addr_inst_ram (addr_inst_ram),
        .din_inst_ram  (din_inst_ram),
        .dout_inst_ram (dout_inst_ram),
        .finish        (finish)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs with one-cycle read latency, a bench-side load port
    // and a store monitor.
    always @(posedge clk) begin
        dout_inst_ram <= inst_mem[addr_inst_ram];
        dout_data_ram <= data_mem[addr_data_ram];
        if (data_ram_we) begin
            data_mem[addr_data_ram] <= din_data_ram;
            we_count <= we_count + 1;
        end else if (ld_we) begin
            data_mem[ld_addr] <= ld_data;
        end
        if (data_ram_we && we_prev) begin
            we_burst_seen <= 1'b1;
        end
        we_prev <= data_ram_we;
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [15:0] imm);
        enc = {op, rd, rs, rt, imm};
    endfunction

    task automatic clear_program();
        for (int i = 0; i < 1024; i++) begin
            inst_mem[i] = 32'h0000_0000;
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    task automatic hold_reset();
        reset  = 1'b0;
        enable = 1'b0;
        #1;
    endtask

    task automatic release_and_run();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
    endtask

    task automatic run_to_finish(input int limit, output int n);
        n = 0;
        while (finish !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if ({data_ram_we, addr_data_ram, din_data_ram, inst_ram_we,
             addr_inst_ram, din_inst_ram, finish} !== 78'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got we=%b addr=%h din=%h iwe=%b iaddr=%h idin=%h fin=%b required all zero",
                     data_ram_we, addr_data_ram, din_data_ram, inst_ram_we, addr_inst_ram, din_inst_ram, finish);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (addr_inst_ram !== 10'h000 || finish !== 1'b0 || data_ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frozen_after_reset: got iaddr=%h fin=%b we=%b required 000 0 0",
                     addr_inst_ram, finish, data_ram_we);
        end
    endtask

    task automatic test_basic();
        int n;
        int w0;
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
        inst_mem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0007);
        inst_mem[2] = enc(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0000);
        inst_mem[3] = enc(OP_ST,  4'd0, 4'd0, 4'd3, 16'h0000);
        inst_mem[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0000, 8'h00);
        release_and_run();
        run_to_finish(200, n);
        checks++;
        if (n !== 20) begin
            errors++;
            $display("[TB] FAIL basic_cycles: got %0d required 20", n);
        end
        checks++;
        if (data_mem[16'h0000] !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL basic_store: got %h required 0c", data_mem[16'h0000]);
        end
        w0 = we_count;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (finish !== 1'b1 || we_count !== w0) begin
            errors++;
            $display("[TB] FAIL basic_done_hold: got fin=%b writes=%0d required 1 0", finish, we_count - w0);
        end
    endtask

    task automatic test_load();
        int n;
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LD,   4'd4, 4'd0, 4'd0, 16'h0010);
        inst_mem[1] = enc(OP_ADDI, 4'd4, 4'd4, 4'd0, 16'h0001);
        inst_mem[2] = enc(OP_ST,   4'd0, 4'd0, 4'd4, 16'h0011);
        inst_mem[3] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0010, 8'hA5);
        poke(16'h0011, 8'h00);
        release_and_run();
        run_to_finish(200, n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("[TB] FAIL load_cycles: got %0d required 18", n);
        end
        checks++;
        if (data_mem[16'h0011] !== 8'hA6) begin
            errors++;
            $display("[TB] FAIL load_result: got %h required a6", data_mem[16'h0011]);
        end
        checks++;
        if (data_mem[16'h0010] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL load_source_kept: got %h required a5", data_mem[16'h0010]);
        end
    endtask

    task automatic test_loop();
        int n;
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h0003);
        inst_mem[1] = enc(OP_ADDI, 4'd1, 4'd1, 4'd0, 16'hFFFF);
        inst_mem[2] = enc(OP_JNZ,  4'd0, 4'd1, 4'd0, 16'h0001);
        inst_mem[3] = enc(OP_ST,   4'd0, 4'd0, 4'd1, 16'h0020);
        inst_mem[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0020, 8'hFF);
        release_and_run();
        run_to_finish(400, n);
        checks++;
        if (n !== 36) begin
            errors++;
            $display("[TB] FAIL loop_cycles: got %0d required 36", n);
        end
        checks++;
        if (data_mem[16'h0020] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL loop_final_r1: got %h required 00", data_mem[16'h0020]);
        end
    endtask

    task automatic test_enable_gap();
        int n;
        int w0;
        int wgap;
        logic gap_we;
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
        inst_mem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0007);
        inst_mem[2] = enc(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0000);
        inst_mem[3] = enc(OP_ST,  4'd0, 4'd0, 4'd3, 16'h0000);
        inst_mem[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0000, 8'h00);
        w0 = we_count;
        release_and_run();
        repeat (15) @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        gap_we = data_ram_we;
        wgap = we_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            gap_we = gap_we | data_ram_we;
        end
        checks++;
        if (gap_we !== 1'b0 || we_count !== wgap) begin
            errors++;
            $display("[TB] FAIL gap_no_write: got we_seen=%b writes=%0d required 0 0", gap_we, we_count - wgap);
        end
        enable = 1'b1;
        run_to_finish(200, n);
        checks++;
        if (15 + 10 + n !== 30) begin
            errors++;
            $display("[TB] FAIL gap_cycles: got %0d required 30", 15 + 10 + n);
        end
        checks++;
        if (data_mem[16'h0000] !== 8'h0C || we_count - w0 !== 1) begin
            errors++;
            $display("[TB] FAIL gap_result: got %h writes=%0d required 0c 1", data_mem[16'h0000], we_count - w0);
        end
    endtask

    task automatic test_rearm();
        int n;
        poke(16'h0000, 8'h00);
        checks++;
        if (finish !== 1'b1 || addr_inst_ram !== 10'd4) begin
            errors++;
            $display("[TB] FAIL rearm_before: got fin=%b pc=%0d required 1 4", finish, addr_inst_ram);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (finish !== 1'b0 || addr_inst_ram !== 10'd0) begin
            errors++;
            $display("[TB] FAIL rearm_clear: got fin=%b pc=%0d required 0 0", finish, addr_inst_ram);
        end
        enable = 1'b1;
        run_to_finish(200, n);
        checks++;
        if (n !== 20 || data_mem[16'h0000] !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL rearm_rerun: got cycles=%0d mem=%h required 20 0c", n, data_mem[16'h0000]);
        end
    endtask

    task automatic test_reset_mid_store();
        int w0;
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0005);
        inst_mem[1] = enc(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0007);
        inst_mem[2] = enc(OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0000);
        inst_mem[3] = enc(OP_ST,  4'd0, 4'd0, 4'd3, 16'h0000);
        inst_mem[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0000, 8'h77);
        release_and_run();
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (data_ram_we !== 1'b1 || addr_data_ram !== 16'h0000 || din_data_ram !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL store_ex_bus: got we=%b addr=%h din=%h required 1 0000 0c",
                     data_ram_we, addr_data_ram, din_data_ram);
        end
        w0 = we_count;
        reset = 1'b0;
        #1;
        checks++;
        if ({data_ram_we, addr_data_ram, din_data_ram, inst_ram_we,
             addr_inst_ram, din_inst_ram, finish} !== 78'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got we=%b addr=%h din=%h iaddr=%h fin=%b required all zero",
                     data_ram_we, addr_data_ram, din_data_ram, addr_inst_ram, finish);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_count !== w0 || data_mem[16'h0000] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL reset_mid_nowrite: got writes=%0d mem=%h required 0 77", we_count - w0, data_mem[16'h0000]);
        end
        enable = 1'b0;
    endtask

    task automatic test_alu_ops();
        int n;
        hold_reset();
        clear_program();
        inst_mem[0]  = enc(OP_LDI,  4'd1, 4'd0, 4'd0, 16'h00F0);
        inst_mem[1]  = enc(OP_LDI,  4'd2, 4'd0, 4'd0, 16'h0F3C);
        inst_mem[2]  = enc(OP_AND,  4'd3, 4'd1, 4'd2, 16'h0000);
        inst_mem[3]  = enc(OP_ST,   4'd0, 4'd0, 4'd3, 16'h0040);
        inst_mem[4]  = enc(OP_OR,   4'd4, 4'd1, 4'd2, 16'h0000);
        inst_mem[5]  = enc(OP_ST,   4'd0, 4'd0, 4'd4, 16'h0041);
        inst_mem[6]  = enc(OP_SUB,  4'd5, 4'd1, 4'd2, 16'h0000);
        inst_mem[7]  = enc(OP_SHR,  4'd6, 4'd5, 4'd0, 16'h0008);
        inst_mem[8]  = enc(OP_ST,   4'd0, 4'd0, 4'd6, 16'h0042);
        inst_mem[9]  = enc(OP_SHL,  4'd7, 4'd1, 4'd0, 16'h0004);
        inst_mem[10] = enc(OP_SHR,  4'd8, 4'd7, 4'd0, 16'h0008);
        inst_mem[11] = enc(OP_ST,   4'd0, 4'd0, 4'd8, 16'h0043);
        inst_mem[12] = enc(OP_LDI,  4'd0, 4'd0, 4'd0, 16'h1234);
        inst_mem[13] = enc(OP_JZ,   4'd0, 4'd0, 4'd0, 16'h000F);
        inst_mem[14] = enc(OP_ST,   4'd0, 4'd0, 4'd1, 16'h0047);
        inst_mem[15] = enc(OP_ST,   4'd0, 4'd0, 4'd0, 16'h0044);
        inst_mem[16] = enc(OP_LDI,  4'd9, 4'd0, 4'd0, 16'hFFFF);
        inst_mem[17] = enc(OP_ST,   4'd0, 4'd9, 4'd1, 16'h0046);
        inst_mem[18] = enc(OP_JNZ,  4'd0, 4'd0, 4'd0, 16'h0014);
        inst_mem[19] = enc(OP_JMP,  4'd0, 4'd0, 4'd0, 16'h0015);
        inst_mem[20] = enc(OP_ST,   4'd0, 4'd0, 4'd1, 16'h0048);
        inst_mem[21] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        for (int a = 16'h40; a <= 16'h48; a++) begin
            poke(16'(a), 8'hEE);
        end
        release_and_run();
        run_to_finish(400, n);
        checks++;
        if (n !== 80) begin
            errors++;
            $display("[TB] FAIL alu_cycles: got %0d required 80", n);
        end
        checks++;
        if ({data_mem[16'h0040], data_mem[16'h0041], data_mem[16'h0042], data_mem[16'h0043]} !== 32'h30FC_F10F) begin
            errors++;
            $display("[TB] FAIL alu_and_or_sub_shift: got %h%h%h%h required 30fcf10f",
                     data_mem[16'h0040], data_mem[16'h0041], data_mem[16'h0042], data_mem[16'h0043]);
        end
        checks++;
        if (data_mem[16'h0044] !== 8'h00 || data_mem[16'h0047] !== 8'hEE) begin
            errors++;
            $display("[TB] FAIL r0_zero_jz: got r0=%h skipped=%h required 00 ee", data_mem[16'h0044], data_mem[16'h0047]);
        end
        checks++;
        if (data_mem[16'h0045] !== 8'hF0 || data_mem[16'h0046] !== 8'hEE) begin
            errors++;
            $display("[TB] FAIL ea_wrap: got 45=%h 46=%h required f0 ee", data_mem[16'h0045], data_mem[16'h0046]);
        end
        checks++;
        if (data_mem[16'h0048] !== 8'hEE) begin
            errors++;
            $display("[TB] FAIL jnz_jmp_skip: got %h required ee", data_mem[16'h0048]);
        end
    endtask

    task automatic test_pc_wrap();
        int n;
        hold_reset();
        clear_program();
        inst_mem[0]    = enc(OP_JNZ,  4'd0,  4'd10, 4'd0,  16'h0003);
        inst_mem[1]    = enc(OP_LDI,  4'd10, 4'd0,  4'd0,  16'h0001);
        inst_mem[2]    = enc(OP_JMP,  4'd0,  4'd0,  4'd0,  16'h03FF);
        inst_mem[3]    = enc(OP_ST,   4'd0,  4'd0,  4'd10, 16'h0050);
        inst_mem[4]    = enc(OP_HALT, 4'd0,  4'd0,  4'd0,  16'h0000);
        inst_mem[1023] = enc(OP_NOP,  4'd0,  4'd0,  4'd0,  16'h0000);
        poke(16'h0050, 8'h00);
        release_and_run();
        run_to_finish(400, n);
        checks++;
        if (n !== 28 || data_mem[16'h0050] !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got cycles=%0d mem=%h required 28 01", n, data_mem[16'h0050]);
        end
    endtask

    task automatic test_mul();
        int n;
        logic [15:0] exp_pair;
`ifdef CPU_CORE_MUL_EN
        exp_pair = 16'h0030;
`else
        exp_pair = 16'h5500;
`endif
        hold_reset();
        clear_program();
        inst_mem[0] = enc(OP_LDI,  4'd5, 4'd0, 4'd0, 16'h0010);
        inst_mem[1] = enc(OP_LDI,  4'd6, 4'd0, 4'd0, 16'h0300);
        inst_mem[2] = enc(OP_LDI,  4'd7, 4'd0, 4'd0, 16'h0055);
        inst_mem[3] = enc(OP_MUL,  4'd7, 4'd5, 4'd6, 16'h0000);
        inst_mem[4] = enc(OP_ST,   4'd0, 4'd0, 4'd7, 16'h0030);
        inst_mem[5] = enc(OP_SHR,  4'd8, 4'd7, 4'd0, 16'h0008);
        inst_mem[6] = enc(OP_ST,   4'd0, 4'd0, 4'd8, 16'h0031);
        inst_mem[7] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
        poke(16'h0030, 8'hEE);
        poke(16'h0031, 8'hEE);
        release_and_run();
        run_to_finish(400, n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("[TB] FAIL mul_cycles: got %0d required 32", n);
        end
        checks++;
        if ({data_mem[16'h0030], data_mem[16'h0031]} !== exp_pair) begin
            errors++;
            $display("[TB] FAIL mul_result: got %h%h required %h", data_mem[16'h0030], data_mem[16'h0031], exp_pair);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load();
        test_loop();
        test_enable_gap();
        test_rearm();
        test_reset_mid_store();
        test_alu_ops();
        test_pc_wrap();
        test_mul();
        checks++;
        if (we_burst_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL we_single_cycle: got burst=%b required 0", we_burst_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
